// File: rtl/wired_icache_pkg.sv
// Shared bus and tag types for the wired I-cache and its refill responder.
package wired_icache_pkg;

  localparam logic [2:0] RD_ALLOC = 3'd1;

  typedef struct packed {
    logic        valid;
    logic [31:0] target_paddr;
    logic [2:0]  size;
    logic [2:0]  inv_req;
    logic        uncached_load_req;
  } lsu_bus_req_t;

  typedef struct packed {
    logic        ready;
    logic [63:0] rdata;
    logic        err;
    logic        ack_inv;
  } lsu_bus_resp_t;

  typedef struct packed {
    logic [19:0] p;
    logic        rp;
    logic        d;
    logic [1:0]  rsv;
  } cache_tag_t;

endpackage

// File: rtl/wired_icache_refill.sv
// I-cache miss responder: AXI read burst, line write into data/tag SRAM, 64-bit fetch pair back.
// Optional WIRED_ICACHE_REFILL_LFSR_EN selects an 8-bit LFSR victim instead of round-robin.
module wired_icache_refill
  import wired_icache_pkg::*;
#(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  lsu_bus_req_t             bus_req_i,
  output lsu_bus_resp_t            bus_resp_o,
  output logic                     ar_valid_o,
  input  logic                     ar_ready_i,
  output logic [31:0]              ar_addr_o,
  output logic [7:0]               ar_len_o,
  output logic [2:0]               ar_size_o,
  output logic [3:0]               ar_id_o,
  input  logic                     r_valid_i,
  output logic                     r_ready_o,
  input  logic [31:0]              r_data_i,
  input  logic                     r_last_i,
  output logic [11:0]              sram_addr_o,
  output logic [3:0]               sram_dwe_o,
  output logic [LINE_WORDS*32-1:0] sram_wdata_o,
  output logic [3:0]               sram_twe_o,
  output cache_tag_t               sram_tag_o
);

  localparam int BW = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WB, S_RESP} state_t;

  state_t                       state_q;
  logic [31:3]                  paddr_q;
  logic                         dbl_q;
  logic                         unc_q;
  logic [BW-1:0]                beat_q;
  logic [LINE_WORDS-1:0][31:0]  line_q;
  logic [LINE_WORDS-1:0][31:0]  line_nxt;
  logic [1:0]                   victim;
  logic                         r_hs;
  logic                         accept;

`ifdef WIRED_ICACHE_REFILL_LFSR_EN
  logic [7:0] lfsr_q;
  assign victim = lfsr_q[1:0];
`else
  logic [1:0] rr_q;
  assign victim = rr_q;
`endif

  assign ar_id_o = AXI_ID;
  assign r_hs    = r_valid_i && r_ready_o;
  assign accept  = (state_q == S_IDLE) && bus_req_i.valid &&
                   ((bus_req_i.inv_req == RD_ALLOC) || bus_req_i.uncached_load_req);

  function automatic logic [63:0] pick_rdata(input logic [LINE_WORDS-1:0][31:0] ln,
                                             input logic hi, input logic unc,
                                             input logic dbl);
    if (unc) return dbl ? {ln[1], ln[0]} : {ln[0], ln[0]};
    return hi ? {ln[3], ln[2]} : {ln[1], ln[0]};
  endfunction

  function automatic cache_tag_t mk_tag(input logic [19:0] p);
    cache_tag_t t;
    t    = '0;
    t.p  = p;
    t.rp = 1'b1;
    return t;
  endfunction

  // The beat being accepted this cycle is merged so the last beat reaches SRAM/rdata without a bubble.
  always_comb begin
    line_nxt = line_q;
    if (r_hs) line_nxt[beat_q] = r_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      paddr_q      <= '0;
      dbl_q        <= 1'b0;
      unc_q        <= 1'b0;
      beat_q       <= '0;
      line_q       <= '0;
      ar_valid_o   <= 1'b0;
      ar_addr_o    <= '0;
      ar_len_o     <= '0;
      ar_size_o    <= '0;
      r_ready_o    <= 1'b0;
      sram_addr_o  <= '0;
      sram_dwe_o   <= '0;
      sram_wdata_o <= '0;
      sram_twe_o   <= '0;
      sram_tag_o   <= '0;
      bus_resp_o   <= '0;
`ifdef WIRED_ICACHE_REFILL_LFSR_EN
      lfsr_q       <= 8'h01;
`else
      rr_q         <= 2'd0;
`endif
    end else begin
      sram_dwe_o <= '0;
      sram_twe_o <= '0;
      bus_resp_o <= '0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            paddr_q    <= bus_req_i.target_paddr[31:3];
            dbl_q      <= (bus_req_i.size == 3'd3);
            unc_q      <= bus_req_i.uncached_load_req;
            beat_q     <= '0;
            line_q     <= '0;
            ar_valid_o <= 1'b1;
            ar_size_o  <= 3'd2;
            if (bus_req_i.uncached_load_req) begin
              ar_addr_o <= bus_req_i.target_paddr;
              ar_len_o  <= (bus_req_i.size == 3'd3) ? 8'd1 : 8'd0;
            end else begin
              ar_addr_o <= {bus_req_i.target_paddr[31:4], 4'b0};
              ar_len_o  <= 8'(LINE_WORDS - 1);
            end
            state_q <= S_AR;
          end
        end
        S_AR: begin
          if (ar_ready_i) begin
            ar_valid_o <= 1'b0;
            ar_addr_o  <= '0;
            ar_len_o   <= '0;
            r_ready_o  <= 1'b1;
            state_q    <= S_R;
          end
        end
        S_R: begin
          if (r_hs) begin
            line_q <= line_nxt;
            beat_q <= beat_q + 1'b1;
            if (r_last_i) begin
              r_ready_o <= 1'b0;
              if (unc_q) begin
                bus_resp_o.ready <= 1'b1;
                bus_resp_o.rdata <= pick_rdata(line_nxt, paddr_q[3], 1'b1, dbl_q);
                state_q          <= S_RESP;
              end else begin
                sram_dwe_o   <= 4'b0001 << victim;
                sram_twe_o   <= 4'b0001 << victim;
                sram_addr_o  <= {paddr_q[11:4], 4'b0};
                sram_wdata_o <= line_nxt;
                sram_tag_o   <= mk_tag(paddr_q[31:12]);
                state_q      <= S_WB;
              end
            end
          end
        end
        S_WB: begin
          sram_addr_o      <= '0;
          sram_wdata_o     <= '0;
          sram_tag_o       <= '0;
          bus_resp_o.ready <= 1'b1;
          bus_resp_o.rdata <= pick_rdata(line_q, paddr_q[3], 1'b0, dbl_q);
`ifdef WIRED_ICACHE_REFILL_LFSR_EN
          lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`else
          rr_q   <= rr_q + 2'd1;
`endif
          state_q <= S_RESP;
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wired_icache_refill.sv
// Scoreboard bench for wired_icache_refill: AXI slave model, expected AR/SRAM/response queues.
module tb_wired_icache_refill;
  import wired_icache_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  lsu_bus_req_t  req;
  lsu_bus_resp_t resp;
  logic          ar_valid, ar_ready;
  logic [31:0]   ar_addr;
  logic [7:0]    ar_len;
  logic [2:0]    ar_size;
  logic [3:0]    ar_id;
  logic          r_valid, r_ready, r_last;
  logic [31:0]   r_data;
  logic [11:0]   sram_addr;
  logic [3:0]    dwe, twe;
  logic [127:0]  wdata;
  cache_tag_t    sram_tag;

  always #5 clk = ~clk;

  wired_icache_refill dut (
    .clk(clk), .rst_n(rst_n), .bus_req_i(req), .bus_resp_o(resp),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr), .ar_len_o(ar_len),
    .ar_size_o(ar_size), .ar_id_o(ar_id), .r_valid_i(r_valid), .r_ready_o(r_ready),
    .r_data_i(r_data), .r_last_i(r_last), .sram_addr_o(sram_addr), .sram_dwe_o(dwe),
    .sram_wdata_o(wdata), .sram_twe_o(twe), .sram_tag_o(sram_tag)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_exp_t;
  typedef struct packed { logic [3:0] we; logic [11:0] addr; logic [127:0] line; cache_tag_t tag; } wb_exp_t;
  typedef struct packed { logic [31:0] data; logic last; } beat_t;

  ar_exp_t     exp_ar[$];
  wb_exp_t     exp_wb[$];
  logic [63:0] exp_rd[$];
  beat_t       mem_q[$];

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, ar_cnt = 0, wb_cnt = 0, resp_cnt = 0;
  int   last_ar_cyc = 0, last_wb_cyc = 0, last_rdy_cyc = 0;
  logic [3:0] last_we = '0;
  int   ar_stall = 0;
  logic r_gaps = 1'b0;
  logic [1:0] vict_m = 2'd0;
  logic [7:0] lfsr_m = 8'h01;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AXI read slave: handshakes decided from values stable at the negedge, inputs updated just after posedge
  initial begin
    logic tog, hs_ar, hs_r, active;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_last = 1'b0;
    tog = 1'b0; active = 1'b0;
    forever begin
      @(negedge clk);
      hs_ar = ar_valid && ar_ready;
      hs_r  = r_valid && r_ready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_q.delete();
        active = 1'b0; ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_last = 1'b0;
      end else begin
        if (hs_r && mem_q.size() > 0) begin
          if (mem_q[0].last) active = 1'b0;
          void'(mem_q.pop_front());
        end
        if (hs_ar) active = 1'b1;
        tog = ~tog;
        if (ar_valid && ar_stall > 0) begin
          ar_stall--;
          ar_ready = 1'b0;
        end else ar_ready = ar_valid;
        r_valid = active && (mem_q.size() > 0) && (!r_gaps || tog);
        if (r_valid) begin
          r_data = mem_q[0].data;
          r_last = mem_q[0].last;
        end else begin
          r_data = '0;
          r_last = 1'b0;
        end
      end
    end
  end

  // Output monitor / scoreboard
  initial begin
    logic pv, pr;
    logic [31:0] pa;
    logic [7:0] pl;
    ar_exp_t ea;
    wb_exp_t ew;
    lsu_bus_resp_t er;
    pv = 1'b0; pr = 1'b0; pa = '0; pl = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pv && !pr) begin
          check("ar_held", ar_valid, 1'b1);
          check("ar_addr_stable", ar_addr, pa);
          check("ar_len_stable", ar_len, pl);
        end
        if (ar_valid && ar_ready) begin
          ar_cnt++;
          last_ar_cyc = cyc;
          if (exp_ar.size() == 0) check("ar_unexpected", exp_ar.size(), 1);
          else begin
            ea = exp_ar.pop_front();
            check("ar_addr", ar_addr, ea.addr);
            check("ar_len", ar_len, ea.len);
            check("ar_size", ar_size, 3'd2);
            check("ar_id", ar_id, 4'd0);
          end
        end
        pv = ar_valid; pr = ar_ready; pa = ar_addr; pl = ar_len;
        if (dwe != 4'b0 || twe != 4'b0) begin
          wb_cnt++;
          last_wb_cyc = cyc;
          last_we = dwe;
          if (exp_wb.size() == 0) check("wb_unexpected", exp_wb.size(), 1);
          else begin
            ew = exp_wb.pop_front();
            check("sram_dwe", dwe, ew.we);
            check("sram_twe", twe, ew.we);
            check("sram_addr", sram_addr, ew.addr);
            check("sram_wdata", wdata, ew.line);
            check("sram_tag", sram_tag, ew.tag);
          end
        end
        if (resp.ready) begin
          resp_cnt++;
          last_rdy_cyc = cyc;
          if (exp_rd.size() == 0) check("resp_unexpected", exp_rd.size(), 1);
          else begin
            er = '0;
            er.ready = 1'b1;
            er.rdata = exp_rd.pop_front();
            check("resp", resp, er);
          end
        end
      end else pv = 1'b0;
    end
  end

  task automatic take_way(output logic [3:0] w);
`ifdef WIRED_ICACHE_REFILL_LFSR_EN
    w = 4'b0001 << lfsr_m[1:0];
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`else
    w = 4'b0001 << vict_m;
    vict_m = vict_m + 2'd1;
`endif
  endtask

  task automatic push_txn(input logic [31:0] pa, input logic [2:0] sz, input logic unc, input int nb,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] w [4];
    logic [3:0] way;
    wb_exp_t ew;
    cache_tag_t t;
    w[0] = d0; w[1] = d1; w[2] = d2; w[3] = d3;
    for (int i = nb; i < 4; i++) w[i] = '0;
    for (int i = 0; i < nb; i++) mem_q.push_back('{data: w[i], last: (i == nb - 1)});
    if (unc) begin
      exp_ar.push_back('{addr: pa, len: (sz == 3'd3) ? 8'd1 : 8'd0});
      exp_rd.push_back((sz == 3'd3) ? {w[1], w[0]} : {w[0], w[0]});
    end else begin
      exp_ar.push_back('{addr: {pa[31:4], 4'h0}, len: 8'd3});
      take_way(way);
      t = '0; t.p = pa[31:12]; t.rp = 1'b1;
      ew.we = way; ew.addr = {pa[11:4], 4'h0}; ew.line = {w[3], w[2], w[1], w[0]}; ew.tag = t;
      exp_wb.push_back(ew);
      exp_rd.push_back(pa[3] ? {w[3], w[2]} : {w[1], w[0]});
    end
  endtask

  task automatic drive_req(input logic v, input logic [31:0] pa, input logic [2:0] sz,
                           input logic [2:0] inv, input logic unc);
    req = '0;
    req.valid = v; req.target_paddr = pa; req.size = sz; req.inv_req = inv; req.uncached_load_req = unc;
  endtask

  task automatic wait_resp(input int target, input string name);
    int n = 0;
    while (resp_cnt < target && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (resp_cnt < target) check(name, resp_cnt, target);
  endtask

  task automatic wait_ar(input int target, input string name);
    int n = 0;
    while (ar_cnt < target && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (ar_cnt < target) check(name, ar_cnt, target);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic run_txn(input logic [31:0] pa, input logic [2:0] sz, input logic unc, input int nb,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3, output int t0);
    int tgt;
    push_txn(pa, sz, unc, nb, d0, d1, d2, d3);
    drive_req(1'b1, pa, sz, unc ? 3'd0 : RD_ALLOC, unc);
    t0 = cyc;
    tgt = resp_cnt + 1;
    wait_resp(tgt, "resp_timeout");
    drive_req(1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    int t0, n0, w0, a0, a_rdy;
    logic [3:0] rr_exp [4];
    rr_exp[0] = 4'b0010; rr_exp[1] = 4'b0100; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0001;
    drive_req(1'b0, '0, '0, '0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check("rst_ar_valid", ar_valid, 1'b0);
    check("rst_r_ready", r_ready, 1'b0);
    check("rst_resp", resp, '0);
    check("rst_dwe", dwe, 4'b0);
    check("rst_twe", twe, 4'b0);
    check("rst_ar_addr", ar_addr, 32'h0);
    check("rst_ar_size", ar_size, 3'd0);
    check("rst_wdata", wdata, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Basic refill with latency checks
    run_txn(32'h1C00_0018, 3'd2, 1'b0, 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3, t0);
    check("lat_ar", last_ar_cyc - t0, 1);
    check("lat_wb", last_wb_cyc - t0, 6);
    check("lat_ready", last_rdy_cyc - t0, 7);
    check("first_way", last_we, 4'b0001);
    check("first_rdata_hi", resp_cnt, 1);

    // Victim sequence
    for (int k = 0; k < 4; k++) begin
      run_txn(32'h0000_1000 + 32'(k) * 32'h110, 3'd2, 1'b0, 4,
              32'h100 + 32'(k), $urandom, $urandom, $urandom, t0);
`ifndef WIRED_ICACHE_REFILL_LFSR_EN
      check("rr_way", last_we, rr_exp[k]);
`endif
    end

    // Uncached loads
    w0 = wb_cnt;
    run_txn(32'h1FC0_0000, 3'd3, 1'b1, 2, 32'h11, 32'h22, 32'h0, 32'h0, t0);
    run_txn(32'h1FC0_0008, 3'd2, 1'b1, 1, 32'h33, 32'h0, 32'h0, 32'h0, t0);
    check("unc_no_wb", wb_cnt - w0, 0);

    // Backpressure
    n0 = resp_cnt;
    ar_stall = 3; r_gaps = 1'b1;
    run_txn(32'h0000_1230, 3'd2, 1'b0, 4, $urandom, $urandom, $urandom, $urandom, t0);
    check("bp_ar_wait", last_ar_cyc - t0, 4);
    idle(3);
    check("bp_one_ready", resp_cnt - n0, 1);
    r_gaps = 1'b0;

    // Early r_last leaves the remaining words zero
    run_txn(32'h0000_2008, 3'd2, 1'b0, 2, 32'hE0, 32'hE1, 32'h0, 32'h0, t0);

    // Unsupported request is ignored
    a0 = ar_cnt; n0 = resp_cnt;
    drive_req(1'b1, 32'h0000_3000, 3'd2, 3'd2, 1'b0);
    idle(10);
    drive_req(1'b0, '0, '0, '0, 1'b0);
    check("ignored_no_ar", ar_cnt - a0, 0);
    check("ignored_no_ready", resp_cnt - n0, 0);
    idle(2);

    // Requester drops valid after AR, then a new request waits for idle
    n0 = resp_cnt; a0 = ar_cnt;
    r_gaps = 1'b1;
    push_txn(32'h00AB_C008, 3'd2, 1'b0, 4, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
    drive_req(1'b1, 32'h00AB_C008, 3'd2, RD_ALLOC, 1'b0);
    wait_ar(a0 + 1, "drop_ar_timeout");
    drive_req(1'b0, 32'hDEAD_BEE0, 3'd3, RD_ALLOC, 1'b1);
    idle(1);
    push_txn(32'h1FC0_0010, 3'd3, 1'b1, 2, 32'h55, 32'h66, 32'h0, 32'h0);
    drive_req(1'b1, 32'h1FC0_0010, 3'd3, 3'd0, 1'b1);
    wait_resp(n0 + 1, "drop_a_timeout");
    a_rdy = last_rdy_cyc;
    wait_resp(n0 + 2, "drop_b_timeout");
    drive_req(1'b0, '0, '0, '0, 1'b0);
    check("drop_b_after_idle", last_ar_cyc - a_rdy, 2);
    idle(3);
    check("drop_two_readies", resp_cnt - n0, 2);
    r_gaps = 1'b0;

    // Async reset mid-burst
    a0 = ar_cnt;
    r_gaps = 1'b1;
    push_txn(32'h0000_0040, 3'd2, 1'b0, 4, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
    drive_req(1'b1, 32'h0000_0040, 3'd2, RD_ALLOC, 1'b0);
    wait_ar(a0 + 1, "rst_ar_timeout");
    idle(2);
    check("pre_rst_in_r", r_ready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_r_ready", r_ready, 1'b0);
    check("arst_ar_valid", ar_valid, 1'b0);
    check("arst_resp", resp, '0);
    check("arst_dwe", dwe, 4'b0);
    check("arst_twe", twe, 4'b0);
    check("arst_tag", sram_tag, '0);
    exp_ar.delete(); exp_wb.delete(); exp_rd.delete();
    vict_m = 2'd0; lfsr_m = 8'h01;
    drive_req(1'b0, '0, '0, '0, 1'b0);
    r_gaps = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    run_txn(32'h0000_0050, 3'd2, 1'b0, 4, 32'hD0, 32'hD1, 32'hD2, 32'hD3, t0);
    check("post_rst_lat", last_rdy_cyc - t0, 7);

    idle(5);
    check("exp_ar_empty", exp_ar.size(), 0);
    check("exp_wb_empty", exp_wb.size(), 0);
    check("exp_rd_empty", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
